// File: rtl/mem_access_ctrl.sv
// Memory-stage controller sitting in front of mem_wb_reg.
// Runs one load/store per EX/MEM instruction over a req/ack data bus.
// It stalls the pipeline while the access is outstanding, then presents
// the formatted result for a single cycle.
//
// state | meaning
// IDLE  | decode EX/MEM; pass non-memory ops straight through, accept memory ops
// BUSY  | request held on the bus until ack or timeout
// DONE  | present latched result (or bus error bubble) for one cycle
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  input  logic [31:0] alu_in,
  input  logic [31:0] wdata_in,
  input  logic [1:0]  control_in,
  input  logic [4:0]  regdst_in,
  output logic [31:0] data_out,
  output logic [31:0] alu_out,
  output logic [1:0]  control_out,
  output logic [4:0]  regdst_out,
  output logic        mem_flush,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  // Counter value seen on the last permitted BUSY cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_alu;
  logic [31:0] r_wdata;
  logic [31:0] r_data;
  logic [1:0]  r_size;
  logic [1:0]  r_ctrl;
  logic [4:0]  r_rd;
  logic [3:0]  r_be;
  logic        r_uns;
  logic        r_we;
  logic        r_err;
  logic [7:0]  r_cnt;

  logic        w_mem_op;
  logic        w_misal;
  logic        w_accept;
  logic        w_last;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_mem_op = ex_valid & (mem_read | mem_write);
  assign w_misal  = w_mem_op & ((mem_size == 2'b01) ? alu_in[0]
                                                    : (mem_size[1] & (alu_in[1:0] != 2'b00)));
  assign w_accept = (r_state == S_IDLE) & w_mem_op & ~w_misal;
  assign w_last   = (r_cnt == CNT_LAST);

  // Store byte enables and lane replication from the incoming instruction
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_in;
    case (mem_size)
      2'b00: begin
        w_be    = 4'b0001 << alu_in[1:0];
        w_wdata = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        w_be    = alu_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select (little-endian) and sign/zero extension
  always_comb begin
    case (r_alu[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      2'b00:   w_load = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUSY;
      S_BUSY:  if (dmem_ack || w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Instruction latches, wait counter, captured read data and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu   <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_size  <= '0;
      r_ctrl  <= '0;
      r_rd    <= '0;
      r_be    <= '0;
      r_uns   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_alu   <= alu_in;
          r_wdata <= w_wdata;
          r_size  <= mem_size;
          r_ctrl  <= control_in;
          r_rd    <= regdst_in;
          r_be    <= w_be;
          r_uns   <= load_unsigned;
          r_we    <= mem_write;
          r_data  <= '0;
          r_err   <= 1'b0;
          r_cnt   <= '0;
        end
        S_BUSY: begin
          if (dmem_ack) begin
            r_data <= r_we ? 32'h0 : w_load;
            r_cnt  <= '0;
          end else if (w_last) begin
            r_err <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: bus side from latches, pipeline side per state
  always_comb begin
    dmem_req    = (r_state == S_BUSY);
    dmem_we     = dmem_req & r_we;
    dmem_addr   = {r_alu[31:2], 2'b00};
    dmem_be     = r_be;
    dmem_wdata  = r_wdata;
    data_out    = '0;
    alu_out     = '0;
    control_out = 2'b01;
    regdst_out  = '0;
    mem_flush   = 1'b1;
    stall       = 1'b0;
    misalign    = 1'b0;
    bus_err     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_misal) begin
            misalign = 1'b1;
          end else if (w_mem_op) begin
            stall = 1'b1;
          end else if (ex_valid) begin
            alu_out     = alu_in;
            control_out = control_in;
            regdst_out  = regdst_in;
            mem_flush   = 1'b0;
          end
        end
        S_BUSY: stall = 1'b1;
        S_DONE: begin
          data_out    = r_data;
          alu_out     = r_alu;
          control_out = r_ctrl;
          regdst_out  = r_rd;
          mem_flush   = r_err;
          bus_err     = r_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: decode table, directed multi-cycle
// sequences and randomized accesses checked against a reference model.
module tb_mem_access_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, mem_read, mem_write, load_unsigned;
  logic [1:0]  mem_size, control_in;
  logic [31:0] alu_in, wdata_in;
  logic [4:0]  regdst_in;
  logic [31:0] data_out, alu_out, dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]  control_out;
  logic [4:0]  regdst_out;
  logic        mem_flush, stall, misalign, bus_err, dmem_req, dmem_we, dmem_ack;
  logic [3:0]  dmem_be;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .load_unsigned(load_unsigned),
    .alu_in(alu_in), .wdata_in(wdata_in), .control_in(control_in),
    .regdst_in(regdst_in), .data_out(data_out), .alu_out(alu_out),
    .control_out(control_out), .regdst_out(regdst_out), .mem_flush(mem_flush),
    .stall(stall), .misalign(misalign), .bus_err(bus_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic        ev, rd, wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [1:0]  ctrl;
    logic [4:0]  rdst;
    logic        e_stall, e_flush, e_mis;
    logic [31:0] e_alu;
    logic [1:0]  e_ctrl;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ex_valid = 0; mem_read = 0; mem_write = 0; mem_size = 0; load_unsigned = 0;
    alu_in = 0; wdata_in = 0; control_in = 0; regdst_in = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Reference model
  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    int unsigned off;
    if (size == 2'd0) begin
      off = addr % 4;
      v = (rd >> (8 * off)) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      off = (addr % 4) / 2;
      v = (rd >> (16 * off)) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 4'b0001 << (addr % 4);
    if (size == 2'd1) return 4'b0011 << (addr % 4);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic m_misal(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  // Full accepted transaction: accept cycle, waits+1 BUSY cycles, DONE cycle.
  task automatic access(input logic rd_op, input logic wr_op, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] ctrl, input logic [4:0] rdst, input int waits,
                        input logic [31:0] rdata, input string tag);
    int stalls = 0;
    ex_valid = 1; mem_read = rd_op; mem_write = wr_op; mem_size = size;
    load_unsigned = uns; alu_in = addr; wdata_in = wd; control_in = ctrl; regdst_in = rdst;
    #1;
    chk({tag, " accept_stall"}, stall, 1);
    chk({tag, " accept_flush"}, mem_flush, 1);
    chk({tag, " accept_req"}, dmem_req, 0);
    if (stall) stalls++;
    tick;
    for (int k = 0; k <= waits; k++) begin
      chk({tag, " busy_req"}, dmem_req, 1);
      chk({tag, " busy_we"}, dmem_we, wr_op);
      chk({tag, " busy_addr"}, dmem_addr, addr & 32'hFFFFFFFC);
      chk({tag, " busy_be"}, dmem_be, m_be(size, addr));
      chk({tag, " busy_wdata"}, dmem_wdata, m_wdata(size, wd));
      chk({tag, " busy_flush"}, mem_flush, 1);
      if (stall) stalls++;
      if (k == waits) begin
        dmem_ack = 1; dmem_rdata = rdata;
      end else begin
        dmem_ack = 0; dmem_rdata = $urandom;
      end
      tick;
    end
    dmem_ack = 0;
    dmem_rdata = $urandom;
    #1;
    chk({tag, " done_req"}, dmem_req, 0);
    chk({tag, " done_stall"}, stall, 0);
    chk({tag, " done_flush"}, mem_flush, 0);
    chk({tag, " done_buserr"}, bus_err, 0);
    chk({tag, " done_data"}, data_out, wr_op ? 32'h0 : m_load(size, uns, addr, rdata));
    chk({tag, " done_alu"}, alu_out, addr);
    chk({tag, " done_ctrl"}, control_out, ctrl);
    chk({tag, " done_rd"}, regdst_out, rdst);
    chk({tag, " stall_cycles"}, stalls, waits + 2);
    idle_inputs;
    tick;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    logic        r, w;

    tbl[0] = '{1'b0,1'b0,1'b0,2'b00,32'h0000_0000,2'b10,5'd4, 1'b0,1'b1,1'b0,32'h0,2'b01,5'd0};
    tbl[1] = '{1'b1,1'b0,1'b0,2'b00,32'h0000_1234,2'b10,5'd5, 1'b0,1'b0,1'b0,32'h1234,2'b10,5'd5};
    tbl[2] = '{1'b1,1'b0,1'b0,2'b10,32'hFFFF_FFFF,2'b11,5'd31,1'b0,1'b0,1'b0,32'hFFFF_FFFF,2'b11,5'd31};
    tbl[3] = '{1'b1,1'b1,1'b0,2'b10,32'h0000_0102,2'b11,5'd3, 1'b0,1'b1,1'b1,32'h0,2'b01,5'd0};
    tbl[4] = '{1'b1,1'b0,1'b1,2'b01,32'h0000_0041,2'b00,5'd0, 1'b0,1'b1,1'b1,32'h0,2'b01,5'd0};
    tbl[5] = '{1'b1,1'b0,1'b1,2'b11,32'h0000_0103,2'b00,5'd0, 1'b0,1'b1,1'b1,32'h0,2'b01,5'd0};
    tbl[6] = '{1'b1,1'b1,1'b0,2'b00,32'h0000_0103,2'b11,5'd9, 1'b1,1'b1,1'b0,32'h0,2'b01,5'd0};
    tbl[7] = '{1'b1,1'b1,1'b0,2'b01,32'h0000_0042,2'b11,5'd9, 1'b1,1'b1,1'b0,32'h0,2'b01,5'd0};
    tbl[8] = '{1'b1,1'b1,1'b1,2'b11,32'h0000_0200,2'b00,5'd0, 1'b1,1'b1,1'b0,32'h0,2'b01,5'd0};

    // Reset held two cycles with an add on the inputs; release shows it at once.
    reset = 1;
    idle_inputs;
    ex_valid = 1; alu_in = 32'h1234; control_in = 2'b10; regdst_in = 5'd3;
    tick;
    tick;
    chk("rst_flush", mem_flush, 1);
    chk("rst_ctrl", control_out, 2'b01);
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_alu", alu_out, 0);
    chk("rst_data", data_out, 0);
    reset = 0;
    #1;
    chk("add_alu", alu_out, 32'h1234);
    chk("add_flush", mem_flush, 0);
    chk("add_ctrl", control_out, 2'b10);
    chk("add_rd", regdst_out, 5'd3);
    idle_inputs;
    tick;

    // IDLE decode table; inputs withdrawn before the edge so nothing is accepted.
    for (int i = 0; i < 9; i++) begin
      ex_valid = tbl[i].ev; mem_read = tbl[i].rd; mem_write = tbl[i].wr;
      mem_size = tbl[i].size; alu_in = tbl[i].addr; control_in = tbl[i].ctrl;
      regdst_in = tbl[i].rdst;
      #1;
      chk($sformatf("tbl%0d stall", i), stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d flush", i), mem_flush, tbl[i].e_flush);
      chk($sformatf("tbl%0d misalign", i), misalign, tbl[i].e_mis);
      chk($sformatf("tbl%0d alu", i), alu_out, tbl[i].e_alu);
      chk($sformatf("tbl%0d ctrl", i), control_out, tbl[i].e_ctrl);
      chk($sformatf("tbl%0d rd", i), regdst_out, tbl[i].e_rd);
      chk($sformatf("tbl%0d req", i), dmem_req, 0);
      idle_inputs;
      tick;
    end

    // Directed transactions
    access(1, 0, 2'b10, 0, 32'h100, 32'h0, 2'b11, 5'd7, 0, 32'hDEADBEEF, "wload");
    access(1, 0, 2'b00, 0, 32'h103, 32'h0, 2'b11, 5'd8, 0, 32'h80112233, "bload_s");
    access(1, 0, 2'b00, 1, 32'h103, 32'h0, 2'b11, 5'd8, 1, 32'h80112233, "bload_u");
    access(0, 1, 2'b01, 0, 32'h42, 32'h0000ABCD, 2'b00, 5'd0, 3, 32'h55555555, "hstore");
    access(1, 0, 2'b01, 0, 32'h202, 32'h0, 2'b11, 5'd2, TO - 1, 32'h9ABC1234, "hload_last");

    // Misaligned word load: one-cycle pulse, no bus access
    ex_valid = 1; mem_read = 1; mem_size = 2'b10; alu_in = 32'h102;
    #1;
    chk("mis_pulse", misalign, 1);
    chk("mis_stall", stall, 0);
    chk("mis_flush", mem_flush, 1);
    chk("mis_req", dmem_req, 0);
    tick;
    idle_inputs;
    #1;
    chk("mis_after_pulse", misalign, 0);
    chk("mis_after_req", dmem_req, 0);
    tick;

    // Timeout: no ack for TO BUSY cycles
    ex_valid = 1; mem_read = 1; mem_size = 2'b10; alu_in = 32'h300;
    control_in = 2'b11; regdst_in = 5'd6;
    tick;
    for (int k = 0; k < TO; k++) begin
      chk($sformatf("to_req%0d", k), dmem_req, 1);
      tick;
    end
    chk("to_done_req", dmem_req, 0);
    chk("to_done_buserr", bus_err, 1);
    chk("to_done_flush", mem_flush, 1);
    chk("to_done_stall", stall, 0);
    idle_inputs;
    dmem_ack = 1;
    dmem_rdata = 32'h12345678;
    tick;
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_buserr", bus_err, 0);
    chk("late_ack_flush", mem_flush, 1);
    dmem_ack = 0;
    tick;

    // Reset in the middle of BUSY
    ex_valid = 1; mem_read = 1; mem_size = 2'b10; alu_in = 32'h400;
    tick;
    chk("rb_req1", dmem_req, 1);
    tick;
    chk("rb_req2", dmem_req, 1);
    reset = 1;
    tick;
    chk("rb_req_after", dmem_req, 0);
    chk("rb_stall", stall, 0);
    chk("rb_flush", mem_flush, 1);
    reset = 0;
    idle_inputs;
    dmem_ack = 1;
    dmem_rdata = 32'hCAFEF00D;
    tick;
    chk("rb_idle_req", dmem_req, 0);
    chk("rb_no_result_flush", mem_flush, 1);
    chk("rb_no_result_stall", stall, 0);
    chk("rb_no_result_data", data_out, 0);
    dmem_ack = 0;
    tick;

    // Randomized accesses against the reference model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom;
        ex_valid = 1; alu_in = a; control_in = 2'($urandom); regdst_in = 5'($urandom);
        #1;
        chk("rnd_pass_alu", alu_out, a);
        chk("rnd_pass_ctrl", control_out, control_in);
        chk("rnd_pass_rd", regdst_out, regdst_in);
        chk("rnd_pass_flush", mem_flush, 0);
        idle_inputs;
        tick;
      end else begin
        sz = 2'($urandom_range(0, 3));
        a = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'd1) a = a & 32'hFFFFFFFE;
          else if (sz >= 2'd2) a = a & 32'hFFFFFFFC;
        end
        r = 1'($urandom);
        w = r ? 1'($urandom) : 1'b1;
        if (m_misal(sz, a)) begin
          ex_valid = 1; mem_read = r; mem_write = w; mem_size = sz; alu_in = a;
          #1;
          chk("rnd_mis_pulse", misalign, 1);
          chk("rnd_mis_stall", stall, 0);
          chk("rnd_mis_req", dmem_req, 0);
          idle_inputs;
          tick;
          chk("rnd_mis_idle_req", dmem_req, 0);
        end else begin
          access(r, w, sz, 1'($urandom), a, $urandom, 2'($urandom), 5'($urandom),
                 $urandom_range(0, 4), $urandom, "rnd");
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
